// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the fetch-side stage and the control logic.
//   - state encodings (INF / EX0)
//   - PC select encodings
//   - instruction field bit positions and opcode constants
package cpu_pkg;

    typedef enum logic {
        ST_INF = 1'b0,
        ST_EX0 = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_REL  = 2'b10,
        PS_REG  = 2'b11
    } ps_t;

    // Instruction field positions (16-bit instruction word)
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int DR_MSB  = 11;
    localparam int DR_LSB  = 8;
    localparam int SA_MSB  = 7;
    localparam int SA_LSB  = 4;
    localparam int SB_MSB  = 3;
    localparam int SB_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes decoded by the control logic
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_LD  = 4'h6;
    localparam logic [3:0] OP_ST  = 4'h7;
    localparam logic [3:0] OP_BZ  = 4'h8;
    localparam logic [3:0] OP_BR  = 4'h9;
    localparam logic [3:0] OP_JR  = 4'hA;
    localparam logic [3:0] OP_JAL = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/pc_ir_unit_pc_next.sv
// pc_next: combinational next-PC selection.
// Ports:
//   pc       in   current program counter
//   ps       in   PC select (hold / increment / relative / register)
//   imm      in   8-bit signed branch offset
//   rs_data  in   register value; low PC_W bits form the jump target
//   state    in   INF/EX0; the PC only moves in EX0
//   pc_nxt   out  next program counter, modulo 2^PC_W
module pc_next
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [1:0]      ps,
    input  logic [7:0]      imm,
    input  logic [PC_W-1:0] rs_data,
    input  logic            state,
    output logic [PC_W-1:0] pc_nxt
);

    logic [PC_W-1:0] offset;

    // Size cast of a signed operand sign-extends when widening and
    // truncates when PC_W is narrower than the offset.
    assign offset = PC_W'($signed(imm));

    always_comb begin
        pc_nxt = pc;
        if (state == ST_EX0) begin
            case (ps)
                PS_INC:  pc_nxt = pc + PC_W'(1);
                PS_REL:  pc_nxt = pc + offset;
                PS_REG:  pc_nxt = rs_data;
                default: pc_nxt = pc;
            endcase
        end
    end

endmodule

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: fetch-side stage holding PC, IR and the INF/EX0 state bit.
// Decodes IR into opcode/register/immediate fields and sequences fetch,
// stall, branch, jump and halt under control of ps and il.
// Optional feature macro: RETIRE_CNT_EN (adds saturating retire_cnt output).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ps             PC select from control logic
//   il             instruction load enable
//   mem_instr      instruction word at pc
//   instr_valid    mem_instr valid this cycle
//   rs_data        register value for register-indirect jumps
//   state          0 = INF, 1 = EX0
//   pc             program counter / fetch address
//   opcode..imm    IR field slices
//   link_pc        pc + 1, JAL return address
//   halted         sticky end-of-execution flag
//   retire_cnt     (RETIRE_CNT_EN) count of executed instructions
//
// state | meaning
// ------+------------------------------------------------------
// INF   | fetch: wait for il && instr_valid, then load IR
// EX0   | execute: update pc per ps, return to INF (ps=00 halts)
module pc_ir_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         ps,
    input  logic               il,
    input  logic [INSTR_W-1:0] mem_instr,
    input  logic               instr_valid,
    input  logic [15:0]        rs_data,
    output logic               state,
    output logic [PC_W-1:0]    pc,
    output logic [3:0]         opcode,
    output logic [3:0]         dr,
    output logic [3:0]         sa,
    output logic [3:0]         sb,
    output logic [7:0]         imm,
    output logic [PC_W-1:0]    link_pc,
    output logic               halted
`ifdef RETIRE_CNT_EN
    ,
    output logic [15:0]        retire_cnt
`endif
);

    state_t             st, st_nxt;
    logic               halted_nxt;
    logic               ir_load;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    pc_nxt;

    pc_next #(.PC_W(PC_W)) u_pc_next (
        .pc      (pc),
        .ps      (ps),
        .imm     (ir[IMM_MSB:IMM_LSB]),
        .rs_data (rs_data[PC_W-1:0]),
        .state   (st),
        .pc_nxt  (pc_nxt)
    );

    generate
        if (PC_W < 16) begin : g_rs_hi
            logic unused_rs_hi;
            assign unused_rs_hi = ^rs_data[15:PC_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= ST_INF;
            halted <= 1'b0;
        end else begin
            st     <= st_nxt;
            halted <= halted_nxt;
        end
    end

    always_comb begin
        st_nxt     = st;
        halted_nxt = halted;
        ir_load    = 1'b0;
        if (!halted) begin
            case (st)
                ST_INF: begin
                    if (il && instr_valid) begin
                        ir_load = 1'b1;
                        st_nxt  = ST_EX0;
                    end
                end
                ST_EX0: begin
                    if (ps == PS_HOLD) begin
                        // Halting leaves state in EX0 so the frozen view
                        // still shows the instruction that ended the run.
                        halted_nxt = 1'b1;
                    end else begin
                        st_nxt = ST_INF;
                    end
                end
                default: st_nxt = ST_INF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (!halted) begin
                pc <= pc_nxt;
            end
            if (ir_load) begin
                ir <= mem_instr;
            end
        end
    end

`ifdef RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if ((st == ST_EX0) && !halted && (retire_cnt != 16'hFFFF)) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

    assign state   = st;
    assign opcode  = ir[OP_MSB:OP_LSB];
    assign dr      = ir[DR_MSB:DR_LSB];
    assign sa      = ir[SA_MSB:SA_LSB];
    assign sb      = ir[SB_MSB:SB_LSB];
    assign imm     = ir[IMM_MSB:IMM_LSB];
    assign link_pc = pc + PC_W'(1);

endmodule

// File: tb/tb_pc_ir_unit.sv
module tb_pc_ir_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ps;
    logic        il;
    logic [15:0] mem_instr;
    logic        instr_valid;
    logic [15:0] rs_data;
    logic        state;
    logic [7:0]  pc;
    logic [3:0]  opcode, dr, sa, sb;
    logic [7:0]  imm;
    logic [7:0]  link_pc;
    logic        halted;
`ifdef RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_ir_unit #(.PC_W(8), .INSTR_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps          (ps),
        .il          (il),
        .mem_instr   (mem_instr),
        .instr_valid (instr_valid),
        .rs_data     (rs_data),
        .state       (state),
        .pc          (pc),
        .opcode      (opcode),
        .dr          (dr),
        .sa          (sa),
        .sb          (sb),
        .imm         (imm),
        .link_pc     (link_pc),
        .halted      (halted)
`ifdef RETIRE_CNT_EN
        ,
        .retire_cnt  (retire_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] w);
        il          = 1'b1;
        instr_valid = 1'b1;
        mem_instr   = w;
        step();
        il          = 1'b0;
        instr_valid = 1'b0;
    endtask

    task automatic exec(input logic [1:0] sel, input logic [15:0] rs);
        ps      = sel;
        rs_data = rs;
        step();
    endtask

    initial begin
        rst = 1'b1; ps = 2'b00; il = 1'b0; mem_instr = '0;
        instr_valid = 1'b0; rs_data = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_state", 32'(state), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_imm", 32'(imm), 32'h00);
        check("rst_link", 32'(link_pc), 32'h01);

        // 1. basic fetch + decode, then increment
        fetch(16'h1234);
        check("t1_state", 32'(state), 32'h1);
        check("t1_opcode", 32'(opcode), 32'h1);
        check("t1_dr", 32'(dr), 32'h2);
        check("t1_sa", 32'(sa), 32'h3);
        check("t1_sb", 32'(sb), 32'h4);
        check("t1_imm", 32'(imm), 32'h34);
        check("t1_pc_fetch", 32'(pc), 32'h00);
        exec(2'b01, 16'h0000);
        check("t1_pc_inc", 32'(pc), 32'h01);
        check("t1_state_inf", 32'(state), 32'h0);

        // 2. stall with instr_valid=0, ps nonzero must be ignored in INF
        il = 1'b1; instr_valid = 1'b0; mem_instr = 16'hABCD; ps = 2'b11; rs_data = 16'h0077;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_stall_state", 32'(state), 32'h0);
            check("t2_stall_pc", 32'(pc), 32'h01);
            check("t2_stall_ir", 32'(opcode), 32'h1);
        end
        il = 1'b0; instr_valid = 1'b1;
        step();
        check("t2_il0_state", 32'(state), 32'h0);
        fetch(16'h20FE);
        check("t2_load_state", 32'(state), 32'h1);
        check("t2_load_imm", 32'(imm), 32'hFE);
        exec(2'b01, 16'h0000);
        check("t2_pc", 32'(pc), 32'h02);

        // 3. relative branch backwards, increment wrap, forward wrap
        for (int i = 0; i < 3; i++) begin
            fetch(16'h0000);
            exec(2'b01, 16'h0000);
        end
        check("t3_pc5", 32'(pc), 32'h05);
        fetch(16'h30FE);
        exec(2'b10, 16'h0000);
        check("t3_rel_back", 32'(pc), 32'h03);

        // 4. register jumps and link value
        fetch(16'hA000);
        exec(2'b11, 16'h0010);
        check("t4_jr_10", 32'(pc), 32'h10);
        fetch(16'hB000);
        check("t4_link", 32'(link_pc), 32'h11);
        exec(2'b11, 16'h1242);
        check("t4_jr_42", 32'(pc), 32'h42);
        fetch(16'hA000);
        exec(2'b11, 16'h00FF);
        check("t4_jr_ff", 32'(pc), 32'hFF);
        fetch(16'h0000);
        check("t4_link_wrap", 32'(link_pc), 32'h00);
        exec(2'b01, 16'h0000);
        check("t3_inc_wrap", 32'(pc), 32'h00);
        fetch(16'hA000);
        exec(2'b11, 16'h00FE);
        fetch(16'h9005);
        exec(2'b10, 16'h0000);
        check("t3_rel_wrap", 32'(pc), 32'h03);

        // 5. halt, frozen, reset clears
        fetch(16'hF0AA);
        exec(2'b00, 16'h0000);
        check("t5_halted", 32'(halted), 32'h1);
        check("t5_state", 32'(state), 32'h1);
        il = 1'b1; instr_valid = 1'b1; mem_instr = 16'h1111; ps = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_frz_pc", 32'(pc), 32'h03);
            check("t5_frz_state", 32'(state), 32'h1);
            check("t5_frz_ir", 32'({opcode, imm}), 32'hFAA);
            check("t5_frz_halt", 32'(halted), 32'h1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; il = 1'b0; instr_valid = 1'b0;
        check("t5_rst_halted", 32'(halted), 32'h0);
        check("t5_rst_pc", 32'(pc), 32'h00);
        check("t5_rst_state", 32'(state), 32'h0);
        check("t5_rst_ir", 32'(opcode), 32'h0);

        // reset mid-EX0 abandons the instruction
        fetch(16'h5555);
        rst = 1'b1; ps = 2'b01;
        step();
        rst = 1'b0;
        check("rst_ex0_pc", 32'(pc), 32'h00);
        check("rst_ex0_state", 32'(state), 32'h0);

`ifdef RETIRE_CNT_EN
        // 6. retire counter: 4 instructions plus the halting one
        check("t6_cnt_rst", 32'(retire_cnt), 32'h0);
        for (int i = 0; i < 4; i++) begin
            fetch(16'h1000);
            exec(2'b01, 16'h0000);
        end
        check("t6_cnt4", 32'(retire_cnt), 32'h4);
        fetch(16'hF000);
        exec(2'b00, 16'h0000);
        check("t6_cnt5", 32'(retire_cnt), 32'h5);
        step();
        step();
        check("t6_cnt_hold", 32'(retire_cnt), 32'h5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
